multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Parametrised multi-cycle successor to the one-hot instruction decoder. Decodes a binary opcode and
//  sequences FETCH/DECODE/EXEC/MEM/WB, producing per-state gated datapath controls.
//  Adds a memory req/ack handshake with timeout, branch resolution from PSW flags, single-step mode,
//  and HLT/illegal handling. Sits between instruction/data memory and the RF/ALU/PC datapath.
// PARAMETERS
//  OPC_W        5    opcode width; codes >= 23 are illegal
//  MEM_TIMEOUT  15   max cycles to wait for fetch_ack/mem_ack before bus_err (>=1)
//  STEP_MODE    0    1: after each retired instruction, wait in FETCH for a step pulse
// PORTS
//  clk          in   1      clock
//  rst_n        in   1      synchronous, active-low reset
//  opc          in   OPC_W  opcode field of IR; sampled in DECODE
//  flag_c       in   1      PSW carry; sampled in EXEC
//  flag_z       in   1      PSW zero; sampled in EXEC
//  fetch_ack    in   1      instruction memory ack
//  mem_ack      in   1      data memory ack
//  step         in   1      single-step advance pulse (STEP_MODE=1 only)
//  resume       in   1      leave HALT
//  fetch_req    out  1      instruction fetch request
//  ir_load      out  1      load IR; pulses with fetch_ack
//  pc_load      out  1      PC write enable
//  pc_sel       out  2      0: PC+1, 1: label target, 2: Rm
//  mem_req      out  1      data memory request
//  mem_we       out  1      data memory write (STR)
//  rf_wr_en     out  1      register-file write
//  rf_wr_from   out  1      1: ALU, 0: memory/link
//  rf_rt_addr   out  1      read-port select (LHI/STR/JR)
//  imm5or8      out  1      1: imm5 (ADDI/SUBI/LDR/STR)
//  jal          out  1      link write (JAL_Label/JAL_Rm)
//  alu_b        out  1      1: register B operand
//  alu_op       out  1      1: subtract
//  alu_psw_en   out  1      PSW update enable
//  alu_target   out  2      bit0 ADC/SBB/LLI, bit1 LHI/LLI
//  out_en       out  1      OutR strobe
//  halted       out  1      in HALT
//  illegal_op   out  1      1-cycle pulse in DECODE for an illegal opcode
//  bus_err      out  1      sticky memory-timeout flag; cleared only by reset
//  state        out  3      current state encoding (debug)
// BEHAVIOUR
//  - Reset: state=FETCH; all outputs 0; timeout counter 0. Reset mid-transaction drops req with no completion.
//  - FETCH: fetch_req=1 until fetch_ack; on ack ir_load=1, pc_load=1, pc_sel=0, goto DECODE.
//    In STEP_MODE, fetch_req is withheld until step=1 (after reset the first fetch also waits for step).
//  - DECODE: latch opc; goto EXEC. Illegal opcode: illegal_op=1, retire as NOP, goto FETCH. HLT: goto HALT.
//  - EXEC: alu_psw_en=1 for ADDI/SUBI/ADD/ADC/SUB/SBB/CMP; alu_op/alu_b/alu_target/imm5or8/rf_rt_addr
//    are static decodes held valid DECODE..WB.
//    Branch taken: BCC !C, BCS C, BNE !Z, BEQ Z, BAL/JMP/JAL_Label always; pc_load=1, pc_sel=1.
//    JAL_Rm/JR: pc_load=1, pc_sel=2. Untaken branch: no pc_load.
//    Next state: LDR/STR -> MEM; CMP, branches, JMP, JR -> FETCH; OutR: out_en=1, -> FETCH; else -> WB.
//  - MEM: mem_req=1 (mem_we=1 for STR) until mem_ack; STR -> FETCH, LDR -> WB.
//  - WB: rf_wr_en=1 for one cycle; rf_wr_from=1 except LDR/JAL; jal=1 for JAL_*; -> FETCH.
//  - Latency (zero-wait memory): ALU op 4 cycles, CMP/branch 3, STR 4, LDR 5.
//  - Timeout: counter increments each cycle a req is unacked and clears on ack or state change;
//    reaching MEM_TIMEOUT sets bus_err and goes to HALT with req deasserted.
//  - HALT: halted=1, all enables 0; resume=1 -> FETCH. resume is ignored while bus_err=1.
//  - An ack arriving in the same cycle the counter reaches MEM_TIMEOUT wins: the transfer completes
//    and bus_err stays 0.
//  - Ack inputs outside FETCH/MEM are ignored. A step pulse outside the FETCH wait is ignored.
// STRUCTURE
//  Package ctrl_pkg: opcode localparams MOV=0,ADDI=1,SUBI=2,LHI=3,LLI=4,LDR=5,STR=6,ADD=7,ADC=8,
//    SUB=9,SBB=10,CMP=11,BCC=12,BCS=13,BNE=14,BEQ=15,BAL=16,JMP=17,JAL_LABEL=18,JAL_RM=19,JR=20,
//    OUTR=21,HLT=22; state enum FETCH=0,DECODE=1,EXEC=2,MEM=3,WB=4,HALT=5; pc_sel codes.
//  Sub-module instr_decode: combinational opcode -> static control bundle. The FSM and timeout
//    counter stay in the top module.
// TESTING
//  1 ADD (7), zero-wait acks -> rf_wr_en high in cycle 4 only, alu_psw_en in cycle 3, alu_b=1.
//  2 BEQ (15) with flag_z=0 then 1 -> no pc_load in EXEC, then pc_load=1 with pc_sel=1.
//  3 LDR (5) with mem_ack delayed 3 cycles -> mem_req held 4 cycles; WB with rf_wr_from=0; 8 cycles total.
//  4 STR, mem_ack never asserted, MEM_TIMEOUT=15 -> bus_err=1 and halted=1 after 15 MEM cycles;
//    resume ignored.
//  5 opc=25 -> illegal_op pulse, no enables, back to FETCH. HLT -> halted; resume -> fetch_req.
//  6 rst_n=0 mid-MEM -> next cycle state=FETCH, all outputs 0. STEP_MODE=1 -> no fetch_req until step.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: opcode numbers, FSM
// state encoding, PC source select codes and the static control bundle that
// instr_decode hands to the sequencer.
package ctrl_pkg;

  localparam int MOV = 0,  ADDI = 1,  SUBI = 2,  LHI = 3,  LLI = 4,  LDR = 5,
                 STR = 6,  ADD  = 7,  ADC  = 8,  SUB = 9,  SBB = 10, CMP = 11,
                 BCC = 12, BCS  = 13, BNE  = 14, BEQ = 15, BAL = 16, JMP = 17,
                 JAL_LABEL = 18, JAL_RM = 19, JR = 20, OUTR = 21, HLT = 22;
  localparam int NUM_OPS = 23;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [1:0] PC_INC   = 2'd0;
  localparam logic [1:0] PC_LABEL = 2'd1;
  localparam logic [1:0] PC_REG   = 2'd2;

  // Branch flavour resolved in EXEC.
  typedef enum logic [2:0] {
    BR_NONE, BR_CC, BR_CS, BR_NE, BR_EQ, BR_AL, BR_REG
  } br_t;

  typedef struct packed {
    logic       illegal;
    logic       hlt;
    logic       ldr;
    logic       str;
    logic       wb;          // instruction ends with a register write
    logic       wb_alu;      // WB source is the ALU (else memory/link)
    logic       jal;
    logic       out;
    logic       psw_en;
    logic       alu_op;
    logic       alu_b;
    logic [1:0] alu_target;
    logic       imm5or8;
    logic       rf_rt_addr;
    br_t        br;
  } ctrl_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode -> static control bundle.
//   opc  : binary opcode (any code >= NUM_OPS is flagged illegal)
//   ctrl : control bundle consumed by the sequencer
module instr_decode import ctrl_pkg::*; #(
  parameter int OPC_W = 5
) (
  input  logic [OPC_W-1:0] opc,
  output ctrl_t            ctrl
);

  int unsigned code;

  always_comb begin
    code = int'(opc);
    ctrl = '0;
    ctrl.br = BR_NONE;
    if (code >= NUM_OPS) begin
      ctrl.illegal = 1'b1;
    end else begin
      case (code)
        MOV:       begin ctrl.wb = 1'b1; ctrl.wb_alu = 1'b1; end
        ADDI:      begin ctrl.wb = 1'b1; ctrl.wb_alu = 1'b1; ctrl.psw_en = 1'b1; ctrl.imm5or8 = 1'b1; end
        SUBI:      begin ctrl.wb = 1'b1; ctrl.wb_alu = 1'b1; ctrl.psw_en = 1'b1; ctrl.imm5or8 = 1'b1;
                         ctrl.alu_op = 1'b1; end
        LHI:       begin ctrl.wb = 1'b1; ctrl.wb_alu = 1'b1; ctrl.alu_target = 2'b10; ctrl.rf_rt_addr = 1'b1; end
        LLI:       begin ctrl.wb = 1'b1; ctrl.wb_alu = 1'b1; ctrl.alu_target = 2'b11; end
        LDR:       begin ctrl.ldr = 1'b1; ctrl.wb = 1'b1; ctrl.imm5or8 = 1'b1; end
        STR:       begin ctrl.str = 1'b1; ctrl.imm5or8 = 1'b1; ctrl.rf_rt_addr = 1'b1; end
        ADD:       begin ctrl.wb = 1'b1; ctrl.wb_alu = 1'b1; ctrl.psw_en = 1'b1; ctrl.alu_b = 1'b1; end
        ADC:       begin ctrl.wb = 1'b1; ctrl.wb_alu = 1'b1; ctrl.psw_en = 1'b1; ctrl.alu_b = 1'b1;
                         ctrl.alu_target = 2'b01; end
        SUB:       begin ctrl.wb = 1'b1; ctrl.wb_alu = 1'b1; ctrl.psw_en = 1'b1; ctrl.alu_b = 1'b1;
                         ctrl.alu_op = 1'b1; end
        SBB:       begin ctrl.wb = 1'b1; ctrl.wb_alu = 1'b1; ctrl.psw_en = 1'b1; ctrl.alu_b = 1'b1;
                         ctrl.alu_op = 1'b1; ctrl.alu_target = 2'b01; end
        CMP:       begin ctrl.psw_en = 1'b1; ctrl.alu_b = 1'b1; ctrl.alu_op = 1'b1; end
        BCC:       ctrl.br = BR_CC;
        BCS:       ctrl.br = BR_CS;
        BNE:       ctrl.br = BR_NE;
        BEQ:       ctrl.br = BR_EQ;
        BAL, JMP:  ctrl.br = BR_AL;
        JAL_LABEL: begin ctrl.br = BR_AL;  ctrl.wb = 1'b1; ctrl.jal = 1'b1; end
        JAL_RM:    begin ctrl.br = BR_REG; ctrl.wb = 1'b1; ctrl.jal = 1'b1; end
        JR:        begin ctrl.br = BR_REG; ctrl.rf_rt_addr = 1'b1; end
        OUTR:      ctrl.out = 1'b1;
        HLT:       ctrl.hlt = 1'b1;
        default:   ctrl.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory req/ack
// handshake, request timeout, PSW branch resolution, single-step and halt.
// Inputs : clk, rst_n (sync, active low), opc, flag_c, flag_z, fetch_ack,
//          mem_ack, step, resume.
// Outputs: fetch/memory requests, PC/RF/ALU controls gated per state,
//          halted, illegal_op pulse, sticky bus_err, state (debug).
module multicycle_controller import ctrl_pkg::*; #(
  parameter int OPC_W       = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int STEP_MODE   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opc,
  input  logic             flag_c,
  input  logic             flag_z,
  input  logic             fetch_ack,
  input  logic             mem_ack,
  input  logic             step,
  input  logic             resume,
  output logic             fetch_req,
  output logic             ir_load,
  output logic             pc_load,
  output logic [1:0]       pc_sel,
  output logic             mem_req,
  output logic             mem_we,
  output logic             rf_wr_en,
  output logic             rf_wr_from,
  output logic             rf_rt_addr,
  output logic             imm5or8,
  output logic             jal,
  output logic             alu_b,
  output logic             alu_op,
  output logic             alu_psw_en,
  output logic [1:0]       alu_target,
  output logic             out_en,
  output logic             halted,
  output logic             illegal_op,
  output logic             bus_err,
  output logic [2:0]       state
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [OPC_W-1:0] opc_q, dec_opc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, bus_err_q;
  logic             req_wait, timeout, taken;
  ctrl_t            ctrl;

  // DECODE sees the live opcode; later states use the copy latched in DECODE.
  assign dec_opc = (state_q == DECODE) ? opc : opc_q;

  instr_decode #(.OPC_W(OPC_W)) u_dec (.opc(dec_opc), .ctrl(ctrl));

  assign bus_err = bus_err_q;
  assign state   = state_q;

  always_comb begin
    state_d    = state_q;
    fetch_req  = 1'b0;  ir_load    = 1'b0;  pc_load   = 1'b0;  pc_sel   = PC_INC;
    mem_req    = 1'b0;  mem_we     = 1'b0;  rf_wr_en  = 1'b0;  rf_wr_from = 1'b0;
    rf_rt_addr = 1'b0;  imm5or8    = 1'b0;  jal       = 1'b0;  alu_b    = 1'b0;
    alu_op     = 1'b0;  alu_psw_en = 1'b0;  alu_target = 2'b00; out_en  = 1'b0;
    halted     = 1'b0;  illegal_op = 1'b0;
    req_wait   = 1'b0;  timeout    = 1'b0;  taken     = 1'b0;

    case (state_q)
      FETCH: begin
        fetch_req = (STEP_MODE == 0) || armed_q || step;
        if (fetch_req && fetch_ack) begin
          ir_load = 1'b1;
          pc_load = 1'b1;
          pc_sel  = PC_INC;
          state_d = DECODE;
        end else begin
          req_wait = fetch_req;
        end
      end
      DECODE: begin
        illegal_op = ctrl.illegal;
        if (ctrl.illegal)  state_d = FETCH;   // retired as a NOP
        else if (ctrl.hlt) state_d = HALT;
        else               state_d = EXEC;
      end
      EXEC: begin
        alu_psw_en = ctrl.psw_en;
        out_en     = ctrl.out;
        case (ctrl.br)
          BR_CC:   taken = !flag_c;
          BR_CS:   taken = flag_c;
          BR_NE:   taken = !flag_z;
          BR_EQ:   taken = flag_z;
          BR_AL:   taken = 1'b1;
          default: taken = 1'b0;
        endcase
        if (taken) begin
          pc_load = 1'b1;
          pc_sel  = PC_LABEL;
        end else if (ctrl.br == BR_REG) begin
          pc_load = 1'b1;
          pc_sel  = PC_REG;
        end
        if (ctrl.ldr || ctrl.str) state_d = MEM;
        else if (ctrl.wb)         state_d = WB;
        else                      state_d = FETCH;
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = ctrl.str;
        if (mem_ack) state_d = ctrl.str ? FETCH : WB;
        else         req_wait = 1'b1;
      end
      WB: begin
        rf_wr_en   = 1'b1;
        rf_wr_from = ctrl.wb_alu;
        jal        = ctrl.jal;
        state_d    = FETCH;
      end
      HALT: begin
        halted = 1'b1;
        if (resume && !bus_err_q) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (state_q inside {DECODE, EXEC, MEM, WB}) begin
      alu_op     = ctrl.alu_op;
      alu_b      = ctrl.alu_b;
      alu_target = ctrl.alu_target;
      imm5or8    = ctrl.imm5or8;
      rf_rt_addr = ctrl.rf_rt_addr;
    end

    // An ack in the final allowed cycle clears req_wait, so it wins over the timeout.
    if (req_wait && (cnt_q == CNT_W'(MEM_TIMEOUT - 1))) begin
      timeout = 1'b1;
      state_d = HALT;
    end
    cnt_d = (req_wait && !timeout) ? cnt_q + 1'b1 : '0;

    if (!rst_n) begin
      {fetch_req, ir_load, pc_load, pc_sel, mem_req, mem_we, rf_wr_en, rf_wr_from,
       rf_rt_addr, imm5or8, jal, alu_b, alu_op, alu_psw_en, alu_target, out_en,
       halted, illegal_op} = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      opc_q     <= '0;
      cnt_q     <= '0;
      armed_q   <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == DECODE) opc_q <= opc;
      if (timeout) bus_err_q <= 1'b1;
      // A step seen while waiting in FETCH keeps the request up until the fetch completes.
      armed_q <= (STEP_MODE != 0) && (state_q == FETCH) && (state_d == FETCH) && (armed_q || step);
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed scenarios plus random instruction
// streams, checked against per-instruction totals derived from the ISA rules.
module tb_multicycle_controller;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, flag_c, flag_z, fetch_ack, mem_ack, step, resume;
  logic [4:0] opc;
  logic       fetch_req, ir_load, pc_load, mem_req, mem_we, rf_wr_en, rf_wr_from, rf_rt_addr;
  logic       imm5or8, jal, alu_b, alu_op, alu_psw_en, out_en, halted, illegal_op, bus_err;
  logic [1:0] pc_sel, alu_target;
  logic [2:0] state;
  logic       s_fetch_req, s_ir_load, s_pc_load, s_mem_req, s_mem_we, s_rf_wr_en, s_rf_wr_from;
  logic       s_rf_rt_addr, s_imm5or8, s_jal, s_alu_b, s_alu_op, s_alu_psw_en, s_out_en;
  logic       s_halted, s_illegal_op, s_bus_err;
  logic [1:0] s_pc_sel, s_alu_target;
  logic [2:0] s_state;
  logic [20:0] all_o, s_all_o;

  assign all_o = {fetch_req, ir_load, pc_load, pc_sel, mem_req, mem_we, rf_wr_en, rf_wr_from,
                  rf_rt_addr, imm5or8, jal, alu_b, alu_op, alu_psw_en, alu_target, out_en,
                  halted, illegal_op, bus_err};
  assign s_all_o = {s_fetch_req, s_ir_load, s_pc_load, s_pc_sel, s_mem_req, s_mem_we, s_rf_wr_en,
                    s_rf_wr_from, s_rf_rt_addr, s_imm5or8, s_jal, s_alu_b, s_alu_op, s_alu_psw_en,
                    s_alu_target, s_out_en, s_halted, s_illegal_op, s_bus_err};

  multicycle_controller #(.OPC_W(5), .MEM_TIMEOUT(15), .STEP_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .opc(opc), .flag_c(flag_c), .flag_z(flag_z),
    .fetch_ack(fetch_ack), .mem_ack(mem_ack), .step(step), .resume(resume),
    .fetch_req(fetch_req), .ir_load(ir_load), .pc_load(pc_load), .pc_sel(pc_sel),
    .mem_req(mem_req), .mem_we(mem_we), .rf_wr_en(rf_wr_en), .rf_wr_from(rf_wr_from),
    .rf_rt_addr(rf_rt_addr), .imm5or8(imm5or8), .jal(jal), .alu_b(alu_b), .alu_op(alu_op),
    .alu_psw_en(alu_psw_en), .alu_target(alu_target), .out_en(out_en), .halted(halted),
    .illegal_op(illegal_op), .bus_err(bus_err), .state(state));

  multicycle_controller #(.OPC_W(5), .MEM_TIMEOUT(15), .STEP_MODE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .opc(opc), .flag_c(flag_c), .flag_z(flag_z),
    .fetch_ack(fetch_ack), .mem_ack(mem_ack), .step(step), .resume(resume),
    .fetch_req(s_fetch_req), .ir_load(s_ir_load), .pc_load(s_pc_load), .pc_sel(s_pc_sel),
    .mem_req(s_mem_req), .mem_we(s_mem_we), .rf_wr_en(s_rf_wr_en), .rf_wr_from(s_rf_wr_from),
    .rf_rt_addr(s_rf_rt_addr), .imm5or8(s_imm5or8), .jal(s_jal), .alu_b(s_alu_b),
    .alu_op(s_alu_op), .alu_psw_en(s_alu_psw_en), .alu_target(s_alu_target), .out_en(s_out_en),
    .halted(s_halted), .illegal_op(s_illegal_op), .bus_err(s_bus_err), .state(s_state));

  int n_assert = 0;
  int n_fail   = 0;
  int wr_log [32];
  int psw_log[32];
  int alub_log[32];

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Runs one instruction with fw fetch wait cycles and mw memory wait cycles,
  // then compares per-instruction totals with what the ISA rules predict.
  task automatic run_instr(input int op, input int fw, input int mw, input bit c, input bit z);
    bit ill, hlt, mem, wb, tk, rj, psw, sb;
    int n_total, fseen, mseen;
    int c_freq, c_ir, c_pcl, c_pcsel, c_mreq, c_mwe, c_wr, c_wra, c_jal, c_psw, c_out, c_ill, c_aop;
    ill = (op >= NUM_OPS);
    hlt = (op == HLT);
    mem = (op == LDR) || (op == STR);
    wb  = !ill && !hlt && !(op inside {STR, CMP, BCC, BCS, BNE, BEQ, BAL, JMP, JR, OUTR});
    tk  = ((op == BCC) && !c) || ((op == BCS) && c) || ((op == BNE) && !z) ||
          ((op == BEQ) && z) || (op inside {BAL, JMP, JAL_LABEL});
    rj  = op inside {JAL_RM, JR};
    psw = op inside {ADDI, SUBI, ADD, ADC, SUB, SBB, CMP};
    sb  = op inside {SUBI, SUB, SBB, CMP};
    n_total = (fw + 1) + 1 + ((ill || hlt) ? 0 : 1 + (mem ? mw + 1 : 0) + (wb ? 1 : 0));
    {c_freq, c_ir, c_pcl, c_pcsel, c_mreq, c_mwe, c_wr, c_wra} = '0;
    {c_jal, c_psw, c_out, c_ill, c_aop} = '0;
    fseen = 0; mseen = 0;
    opc = op[4:0]; flag_c = c; flag_z = z;
    for (int i = 0; i < n_total; i++) begin
      #1;
      fetch_ack = fetch_req && (fseen == fw);
      mem_ack   = mem_req && (mseen == mw);
      @(negedge clk);
      fseen += int'(fetch_req); mseen += int'(mem_req);
      c_freq += int'(fetch_req); c_ir += int'(ir_load); c_pcl += int'(pc_load);
      c_pcsel += pc_load ? int'(pc_sel) : 0;
      c_mreq += int'(mem_req); c_mwe += int'(mem_we); c_wr += int'(rf_wr_en);
      c_wra += int'(rf_wr_en && rf_wr_from); c_jal += int'(jal); c_psw += int'(alu_psw_en);
      c_out += int'(out_en); c_ill += int'(illegal_op); c_aop += int'(alu_op);
      if (i < 32) begin
        wr_log[i] = int'(rf_wr_en); psw_log[i] = int'(alu_psw_en); alub_log[i] = int'(alu_b);
      end
      tick();
    end
    fetch_ack = 1'b0; mem_ack = 1'b0;
    chk($sformatf("op%0d fetch_req_cycles", op), c_freq, fw + 1);
    chk($sformatf("op%0d ir_load", op), c_ir, 1);
    chk($sformatf("op%0d pc_load", op), c_pcl, 1 + int'(!ill && (tk || rj)));
    chk($sformatf("op%0d pc_sel_sum", op), c_pcsel, (!ill && tk) ? 1 : (rj ? 2 : 0));
    chk($sformatf("op%0d mem_req_cycles", op), c_mreq, mem ? mw + 1 : 0);
    chk($sformatf("op%0d mem_we_cycles", op), c_mwe, (op == STR) ? mw + 1 : 0);
    chk($sformatf("op%0d rf_wr_en", op), c_wr, int'(wb));
    chk($sformatf("op%0d rf_wr_from_alu", op), c_wra, int'(wb && !(op inside {LDR, JAL_LABEL, JAL_RM})));
    chk($sformatf("op%0d jal", op), c_jal, int'(op inside {JAL_LABEL, JAL_RM}));
    chk($sformatf("op%0d alu_psw_en", op), c_psw, int'(psw));
    chk($sformatf("op%0d out_en", op), c_out, int'(op == OUTR));
    chk($sformatf("op%0d illegal_op", op), c_ill, int'(ill));
    chk($sformatf("op%0d alu_op_cycles", op), c_aop, sb ? n_total - (fw + 1) : 0);
    chk($sformatf("op%0d end_state", op), int'(state), hlt ? 5 : 0);
  endtask

  task automatic do_resume();
    resume = 1'b1; tick(); resume = 1'b0; #1;
    chk("resume_state", int'(state), 0);
    chk("resume_fetch_req", int'(fetch_req), 1);
  endtask

  initial begin
    int op, n;
    rst_n = 1'b0; opc = '0; flag_c = 1'b0; flag_z = 1'b0;
    fetch_ack = 1'b0; mem_ack = 1'b0; step = 1'b0; resume = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", int'(all_o), 0);
    chk("reset_state", int'(state), 0);
    chk("reset_outputs_step", int'(s_all_o), 0);
    tick(); rst_n = 1'b1;

    // ADD: psw in cycle 3, register write in cycle 4 only, register B operand.
    run_instr(ADD, 0, 0, 1'b0, 1'b0);
    chk("add_psw_cycle3", psw_log[2], 1);
    chk("add_wr_cycle4", wr_log[3], 1);
    chk("add_wr_cycle3", wr_log[2], 0);
    chk("add_alu_b", alub_log[2], 1);
    // BEQ untaken then taken; LDR with a 3-cycle late ack; illegal opcode.
    run_instr(BEQ, 0, 0, 1'b0, 1'b0);
    run_instr(BEQ, 0, 0, 1'b0, 1'b1);
    run_instr(LDR, 0, 3, 1'b0, 1'b0);
    run_instr(25, 0, 0, 1'b0, 1'b0);
    // Acks in the very last allowed cycle complete without bus error.
    run_instr(STR, 0, 14, 1'b0, 1'b0);
    run_instr(MOV, 14, 0, 1'b0, 1'b0);
    chk("late_ack_no_bus_err", int'(bus_err), 0);
    // HLT then resume.
    run_instr(HLT, 0, 0, 1'b0, 1'b0);
    chk("hlt_halted", int'(halted), 1);
    chk("hlt_no_fetch", int'(fetch_req), 0);
    do_resume();

    for (int k = 0; k < 40; k++) begin
      op = int'($urandom_range(0, 31));
      run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (op == HLT) do_resume();
    end

    // STR with no memory ack: timeout after 15 MEM cycles, resume ignored.
    opc = STR[4:0]; #1; fetch_ack = 1'b1; tick(); fetch_ack = 1'b0;
    tick(); tick();
    n = 0;
    repeat (15) begin
      @(negedge clk); n += int'(mem_req); tick();
    end
    chk("timeout_mem_req_cycles", n, 15);
    @(negedge clk);
    chk("timeout_bus_err", int'(bus_err), 1);
    chk("timeout_halted", int'(halted), 1);
    chk("timeout_req_dropped", int'(mem_req), 0);
    resume = 1'b1; tick(); tick(); resume = 1'b0;
    @(negedge clk);
    chk("timeout_resume_ignored", int'(halted), 1);
    tick(); rst_n = 1'b0; tick();
    @(negedge clk);
    chk("reset_clears_bus_err", int'(bus_err), 0);
    tick(); rst_n = 1'b1;

    // Reset in the middle of a memory transfer.
    opc = LDR[4:0]; #1; fetch_ack = 1'b1; tick(); fetch_ack = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("midmem_req", int'(mem_req), 1);
    tick(); rst_n = 1'b0; tick();
    @(negedge clk);
    chk("midmem_reset_state", int'(state), 0);
    chk("midmem_reset_outputs", int'(all_o), 0);
    tick(); rst_n = 1'b1; #1;

    // Single-step instance holds off fetching until a step pulse.
    chk("nostep_fetch_req", int'(fetch_req), 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("step_withheld", int'(s_fetch_req), 0); tick();
    end
    step = 1'b1; #1;
    chk("step_fetch_req", int'(s_fetch_req), 1);
    tick(); step = 1'b0; #1;
    chk("step_armed_fetch_req", int'(s_fetch_req), 1);
    opc = ADD[4:0]; fetch_ack = 1'b1; tick(); fetch_ack = 1'b0; #1;
    chk("step_decode_state", int'(s_state), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
